// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The loader fills instruction memory from a byte stream and then releases the core.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

  localparam int HEADER_BYTES   = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shift register: first byte ends in bits 7:0,
// fourth byte in bits 31:24.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {in_byte, word[31:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // High while the byte completing the current word is being shifted in.
  assign word_full = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: reads a 16-bit LE word count and that many 32-bit LE words from a
// valid/ready byte stream, writes them to instruction memory, then drops core_hold.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int data_bits           = 32,
  parameter int memory_size         = 1024,
  parameter int memory_address_bits = $clog2(memory_size)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           start,
  input  logic [7:0]                     in_byte,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           mem_write_enable,
  output logic [memory_address_bits-1:0] mem_address,
  output logic [data_bits-1:0]           mem_write_data,
  output logic                           core_hold,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output loader_state_t                  state_dbg
);

  // Handshake: a byte moves on any cycle with in_valid && in_ready. in_ready is a
  // pure decode of the registered state, so the source must hold in_byte/in_valid
  // steady until it sees the transfer; nothing is consumed while in_ready is low.

  loader_state_t                  state, state_next;
  logic [15:0]                    count;
  logic [15:0]                    hdr_count;
  logic [memory_address_bits-1:0] word_index;
  logic                           xfer;
  logic                           shift_en;
  logic                           asm_clear;
  logic                           word_full;
  logic                           last_word;
  logic [31:0]                    asm_word;

  assign xfer      = in_valid && in_ready;
  assign shift_en  = xfer && (state == ST_DATA);
  assign hdr_count = {in_byte, count[7:0]};
  assign last_word = (16'(word_index) == (count - 16'd1));

  word_assembler u_word_assembler (
    .clk       (CLK),
    .reset     (RESET),
    .shift_en  (shift_en),
    .clear     (asm_clear),
    .in_byte   (in_byte),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    asm_clear  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (xfer) state_next = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (xfer) begin
          asm_clear = 1'b1;
          if (hdr_count == 16'd0) begin
            state_next = ST_DONE;
          end else if (hdr_count > 16'(memory_size)) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_word) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_DATA;
          asm_clear  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready         = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    error            = 1'b0;
    core_hold        = 1'b1;
    mem_write_enable = 1'b0;
    case (state)
      ST_HDR_LO, ST_HDR_HI, ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_WRITE: begin
        busy             = 1'b1;
        mem_write_enable = 1'b1;
      end
      ST_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // The count check in HDR_HI keeps word_index below memory_size, so it never wraps.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count      <= '0;
      word_index <= '0;
    end else begin
      if (xfer && state == ST_HDR_LO) count[7:0] <= in_byte;
      if (xfer && state == ST_HDR_HI) begin
        count[15:8] <= in_byte;
        word_index  <= '0;
      end
      if (state == ST_WRITE && !last_word) word_index <= word_index + 1'b1;
    end
  end

  assign mem_address    = word_index;
  assign mem_write_data = asm_word;
  assign state_dbg      = state;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a queue of expected (address, word) writes
// derived from the image and the count rules, plus timing and status checks.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int MEM_WORDS = 1024;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          mem_write_enable;
  logic [9:0]    mem_address;
  logic [31:0]   mem_write_data;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;
  loader_state_t state_dbg;

  program_loader #(
    .data_bits   (32),
    .memory_size (MEM_WORDS)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .start            (start),
    .in_byte          (in_byte),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .core_hold        (core_hold),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .state_dbg        (state_dbg)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [41:0] exp_q[$];
  logic [31:0] img_q[$];
  logic [41:0] exp_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest outstanding image word.
  always @(negedge CLK) begin
    if (!RESET && mem_write_enable) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_wr = exp_q.pop_front();
        check("write_addr_data", 64'({mem_address, mem_write_data}), 64'(exp_wr));
      end
    end
  end

  // Drivers
  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("start_in_ready", 64'(in_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_core_hold", 64'(core_hold), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_error_clr", 64'(error), 64'd0);
  endtask

  task automatic put_byte(input logic [7:0] b, input bit gaps, input bit poke);
    bit took;
    took = 1'b0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        @(posedge CLK); #1;
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    start    = poke;
    for (int k = 0; k < 40 && !took; k++) begin
      took = in_ready;
      @(posedge CLK); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
    check("byte_accepted", 64'(took), 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(posedge CLK); #1;
      k++;
    end
    check("settle_timeout", 64'(busy), 64'd0);
  endtask

  // Loads img_q under header cnt; expectations come from the count rules alone.
  task automatic load_image(input logic [15:0] cnt, input bit gaps, input bit poke);
    int          c0;
    int          n_data;
    logic [31:0] w_val;
    bit          is_err;
    is_err = (cnt > MEM_WORDS);
    n_data = (cnt == 0 || is_err) ? 0 : int'(cnt);
    pulse_start();
    c0 = cyc;
    put_byte(cnt[7:0], gaps, poke);
    put_byte(cnt[15:8], gaps, poke);
    for (int w = 0; w < n_data; w++) begin
      w_val = img_q[w];
      exp_q.push_back({10'(w), w_val});
      for (int b = 0; b < 4; b++) begin
        put_byte(w_val[8*b +: 8], gaps, poke && ($urandom_range(3, 0) == 0));
      end
      check("we_after_4th_byte", 64'(mem_write_enable), 64'd1);
    end
    wait_idle();
    check("end_done", 64'(done), 64'(!is_err));
    check("end_error", 64'(is_err), 64'(error));
    check("end_core_hold", 64'(core_hold), 64'(is_err));
    check("end_in_ready", 64'(in_ready), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    if (!gaps) check("load_cycles", 64'(cyc - c0), 64'(HEADER_BYTES + 5 * n_data));
  endtask

  task automatic random_image(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_we"}, 64'(mem_write_enable), 64'd0);
    check({tag, "_addr"}, 64'(mem_address), 64'd0);
    check({tag, "_wdata"}, 64'(mem_write_data), 64'd0);
    check({tag, "_core_hold"}, 64'(core_hold), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Two-word program from the boot example
    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'h0010_0093);
    load_image(16'd2, 1'b0, 1'b0);

    // Empty image: straight to DONE, no writes
    load_image(16'd0, 1'b0, 1'b0);

    // Oversized count: ERROR, and the stream is not consumed
    load_image(16'd1025, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    repeat (3) begin
      @(posedge CLK); #1;
      check("error_in_ready", 64'(in_ready), 64'd0);
      check("error_state", 64'(state_dbg), 64'(ST_ERROR));
    end
    in_valid = 1'b0;

    // Three words with random valid gaps and stray start pulses
    random_image(3);
    load_image(16'd3, 1'b1, 1'b1);
    for (int r = 0; r < 6; r++) begin
      random_image(8);
      load_image(16'($urandom_range(8, 1)), bit'($urandom_range(1, 0)), 1'b1);
    end

    // Reset after two data bytes discards the partial word
    pulse_start();
    put_byte(8'h01, 1'b0, 1'b0);
    put_byte(8'h00, 1'b0, 1'b0);
    put_byte(8'hEF, 1'b0, 1'b0);
    put_byte(8'hBE, 1'b0, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check_reset_outputs("midload_reset");
    img_q.delete();
    img_q.push_back(32'hDEAD_BEEF);
    load_image(16'd1, 1'b0, 1'b0);

    // Reload from DONE with one word, then the largest legal image
    random_image(1);
    load_image(16'd1, 1'b0, 1'b0);
    random_image(MEM_WORDS);
    load_image(16'(MEM_WORDS), 1'b0, 1'b0);
    load_image(16'hFFFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that fills the core's instruction memory from a byte-wide valid/ready stream, then releases the core. It sits beside the core top, drives the write port of the instruction memory and holds the core's PC/fetch path in reset until a complete program image has been written. The stream carries a 16-bit little-endian word count followed by that many 32-bit little-endian instruction words.

## Interface
- data_bits, 32, instruction word width; fixed at 32 for this block.
- memory_size, 1024, instruction memory depth in words.
- memory_address_bits, $clog2(memory_size), word address width.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- in_byte  in  8  stream data byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts in_byte this cycle.
- mem_write_enable  out  1  instruction memory write strobe, one cycle per word.
- mem_address  out  memory_address_bits  word address of the write.
- mem_write_data  out  data_bits  assembled instruction word.
- core_hold  out  1  keeps the core in reset while high.
- busy  out  1  load in progress.
- done  out  1  image loaded successfully.
- error  out  1  header word count exceeds memory_size.

## Operation
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERROR.
- A byte transfer occurs on a cycle with in_valid && in_ready. in_ready is 1 only in HDR_LO, HDR_HI and DATA.
- IDLE: start -> HDR_LO. Otherwise stay in IDLE.
- HDR_LO: transfer -> count[7:0], then HDR_HI.
- HDR_HI: transfer -> count[15:8], then go to:
  - DONE if count == 0;
  - ERROR if count > memory_size;
  - otherwise DATA, with word index = 0 and byte counter = 0.
- DATA: each transfer shifts in a byte, little-endian (1st byte -> bits 7:0, 4th -> bits 31:24). On the 4th byte -> WRITE.
- WRITE (one cycle): mem_write_enable = 1, mem_address = word index, mem_write_data = assembled word.
  - If index == count-1 -> DONE.
  - Otherwise index++, byte counter = 0, back to DATA.
- DONE: done = 1, core_hold = 0. start -> HDR_LO (reload, core_hold returns to 1).
- ERROR: error = 1, core_hold = 1. Exit only via start (-> HDR_LO) or RESET.
- start is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- in_valid without in_ready is not consumed. The source holds the byte until it is accepted.
- Word index wraps never: the count check guarantees index < memory_size.

## Timing
- Reset values: state IDLE, in_ready 0, mem_write_enable 0, mem_address 0, mem_write_data 0, core_hold 1, busy 0, done 0, error 0, count 0.
- RESET mid-load returns to IDLE next edge. The partial word is discarded. Already-written memory words are not cleared.
- All outputs are registered or decoded from registered state only; no combinational in->out paths.
- start at edge t -> in_ready = 1 from cycle t+1.
- 4th byte accepted at edge t -> mem_write_enable high during cycle t+1 -> in_ready high again at t+2.
- Minimum rate: 5 cycles per word, plus 2 header cycles.
- busy = 1 in HDR_LO, HDR_HI, DATA and WRITE.
- done and error are levels, not pulses. Both clear on the cycle after start is taken.
- core_hold falls on the same cycle done rises.

## Structure
- program_loader_pkg holds:
  - the state enum typedef (loader_state_t);
  - HEADER_BYTES = 2;
  - BYTES_PER_WORD = 4.
- Sub-module word_assembler: a 32-bit shift register with a 2-bit byte counter. Inputs shift_en and clear; outputs word and word_full.
- The FSM, word index and count registers live in program_loader.

## Test plan
- Reset then start, stream 02 00 13 00 00 00 93 00 10 00:
  - writes addr0 = 0x00000013 and addr1 = 0x00100093, one write per word;
  - done = 1 and core_hold = 0 two writes later.
- Header 00 00 -> no mem_write_enable pulse; DONE reached directly after HDR_HI; done = 1.
- Header 01 04 (count 1025, memory_size 1024) -> ERROR, error = 1, core_hold = 1, in_ready = 0. A following start returns to HDR_LO with error = 0.
- Random in_valid gaps (50% duty) on a 3-word image:
  - written words match the reference exactly;
  - no byte is dropped or duplicated;
  - start pulses mid-load are ignored.
- RESET asserted after 2 data bytes:
  - all outputs return to their reset values next cycle;
  - a fresh load of 1 word 0xDEADBEEF (bytes EF BE AD DE) writes addr0 = 0xDEADBEEF.
- From DONE, start plus a 1-word image: core_hold rises the cycle after start and falls when done re-asserts.
